// File: rtl/i2c_led_ctrl_if.sv
// Byte-stream bus from the I2C slave to the frame controller.
// The slave side sees one received byte per data_valid plus start/stop strobes.
interface i2c_led_ctrl_if;
  logic [7:0] data;
  logic       data_valid;
  logic       start;
  logic       stop;

  modport master (output data, output data_valid, output start, output stop);
  modport slave  (input  data, input  data_valid, input  start, input  stop);
endinterface

// File: rtl/i2c_led_ctrl.sv
// Frame controller: parses I2C writes (start index + colour bytes) into a working
// buffer and issues a tear-free, coalesced refresh to the WS2812 driver after each stop.
module i2c_led_ctrl #(
  parameter  int LED_CNT   = 3,
  localparam int NBYTES    = LED_CNT * 3,
  localparam int DATAWIDTH = NBYTES * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_led_ctrl_if.slave        bus,
  input  logic                 busy_i,
  output logic [DATAWIDTH-1:0] led_data_o,
  output logic                 upd_o,
  output logic                 pending_o
);

  localparam int             PW      = $clog2(NBYTES);
  localparam logic [7:0]     NB_B    = 8'(NBYTES);
  localparam logic [PW-1:0]  PTR_MAX = PW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic                 dirty_q;
  logic                 pending_q;
  logic                 upd_q;
  logic                 holdoff_q;
  logic [DATAWIDTH-1:0] wbuf_q;
  logic [DATAWIDTH-1:0] led_q;

  logic byte_wr_s;
  logic set_pend_s;
  logic fire_s;

  // A byte arriving together with stop still counts towards this transaction's refresh
  always_comb begin
    byte_wr_s  = (state_q == S_DATA) && bus.data_valid && !bus.start;
    set_pend_s = bus.stop && !bus.start && (dirty_q || byte_wr_s);
    fire_s     = pending_q && !busy_i && !upd_q && !holdoff_q;
  end

  // Transaction parser and working-buffer writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dirty_q <= 1'b0;
      wbuf_q  <= '0;
    end else if (bus.start) begin
      state_q <= S_ADDR;
      dirty_q <= 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (bus.data_valid) begin
            if (bus.data < NB_B) begin
              ptr_q   <= bus.data[PW-1:0];
              state_q <= S_DATA;
            end else begin
              state_q <= S_DROP;
            end
          end
        end
        S_DATA: begin
          if (bus.data_valid) begin
            wbuf_q[DATAWIDTH-1-8*int'(ptr_q) -: 8] <= bus.data;
            dirty_q <= 1'b1;
            ptr_q   <= (ptr_q == PTR_MAX) ? '0 : ptr_q + PW'(1);
          end
        end
        default: state_q <= state_q;
      endcase
      if (bus.stop) begin
        state_q <= S_IDLE;
        dirty_q <= 1'b0;
      end
    end
  end

  // Refresh scheduler; holdoff masks the driver's busy rise right after an update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      holdoff_q <= 1'b0;
      led_q     <= '0;
    end else begin
      pending_q <= set_pend_s || (pending_q && !fire_s);
      upd_q     <= fire_s;
      holdoff_q <= upd_q;
      if (fire_s) begin
        led_q <= wbuf_q;
      end
    end
  end

  assign led_data_o = led_q;
  assign upd_o      = upd_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_i2c_led_ctrl.sv
// Self-checking bench for i2c_led_ctrl: directed and randomized I2C transactions
// checked against a byte-array frame model.
module tb_i2c_led_ctrl;
  localparam int NB = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [71:0] led;
  logic        upd;
  logic        pend;

  i2c_led_ctrl_if bus ();

  i2c_led_ctrl #(.LED_CNT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .busy_i     (busy),
    .led_data_o (led),
    .upd_o      (upd),
    .pending_o  (pend)
  );

  always #5 clk = ~clk;

  int          checks  = 0;
  int          errors  = 0;
  int          upd_cnt = 0;
  logic        upd_prev = 1'b0;
  logic [7:0]  mdl [NB];
  logic [7:0]  pay [$];
  logic [71:0] last_led;

  function automatic logic [71:0] pack();
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[71-8*i -: 8] = mdl[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count update pulses and flag back-to-back pulses
  always @(negedge clk) begin
    if (upd) begin
      upd_cnt++;
      check("upd_not_consecutive", {71'd0, upd_prev}, 72'd0);
    end
    upd_prev = upd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start, index byte, payload, stop (stop in its own cycle); updates the model
  task automatic send_txn(input int idx, output bit wrote);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.data = 8'(idx); bus.data_valid = 1'b1; tick();
    foreach (pay[k]) begin bus.data = pay[k]; tick(); end
    bus.data_valid = 1'b0; bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    wrote = 1'b0;
    if (idx < NB) begin
      foreach (pay[k]) mdl[(idx + k) % NB] = pay[k];
      wrote = (pay.size() > 0);
    end
  endtask

  // Called in the cycle after stop was sampled, driver idle
  task automatic expect_refresh(input string tag);
    check({tag, "_pend"}, {71'd0, pend}, 72'd1);
    check({tag, "_upd_early"}, {71'd0, upd}, 72'd0);
    tick();
    check({tag, "_upd"}, {71'd0, upd}, 72'd1);
    check({tag, "_led"}, led, pack());
    last_led = pack();
    tick();
    check({tag, "_upd_end"}, {71'd0, upd}, 72'd0);
    check({tag, "_pend_end"}, {71'd0, pend}, 72'd0);
  endtask

  task automatic expect_none(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_no_upd"}, {71'd0, upd}, 72'd0);
      check({tag, "_no_pend"}, {71'd0, pend}, 72'd0);
      tick();
    end
    check({tag, "_led_hold"}, led, last_led);
  endtask

  initial begin
    bit          wrote;
    int          base;
    int          idx;
    logic [71:0] frame_a;
    logic [7:0]  d;

    bus.data = 8'd0; bus.data_valid = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    busy = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < NB; i++) mdl[i] = 8'd0;
    last_led = '0;
    tick(); tick();
    check("rst_led", led, 72'd0);
    check("rst_upd", {71'd0, upd}, 72'd0);
    check("rst_pend", {71'd0, pend}, 72'd0);
    reset = 1'b1;
    tick();

    // Full frame
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    send_txn(0, wrote);
    expect_refresh("full");
    check("full_const", led, 72'h112233445566778899);

    // Partial write with wrap
    pay = {8'hAA, 8'hBB};
    send_txn(8, wrote);
    expect_refresh("wrap");
    check("wrap_const", led, 72'hBB22334455667788AA);

    // Out-of-range index and empty transaction
    pay = {8'h55};
    send_txn(9, wrote);
    expect_none("oor");
    pay = {};
    send_txn(0, wrote);
    expect_none("empty");

    // Randomized transactions with the driver idle
    for (int t = 0; t < 8; t++) begin
      idx = $urandom_range(0, 11);
      pay = {};
      for (int k = 0; k < $urandom_range(0, 5); k++) pay.push_back(8'($urandom));
      send_txn(idx, wrote);
      if (wrote) expect_refresh("rand");
      else       expect_none("rand_none");
      tick();
    end

    // Busy coalescing: two transactions during one transmission
    busy = 1'b1;
    base = upd_cnt;
    pay = {8'($urandom), 8'($urandom)};
    send_txn(1, wrote);
    pay = {8'($urandom), 8'($urandom), 8'($urandom)};
    send_txn(4, wrote);
    tick(); tick();
    check("coal_pend", {71'd0, pend}, 72'd1);
    check("coal_no_upd", 72'(upd_cnt - base), 72'd0);
    check("coal_led_hold", led, last_led);
    busy = 1'b0;
    for (int k = 0; k < 8 && !upd; k++) tick();
    check("coal_upd", {71'd0, upd}, 72'd1);
    check("coal_led", led, pack());
    last_led = pack();
    tick(); tick(); tick();
    check("coal_one_upd", 72'(upd_cnt - base), 72'd1);

    // Pending re-set on the firing edge (also data_valid+stop in one cycle)
    busy = 1'b1;
    base = upd_cnt;
    pay = {8'($urandom)};
    send_txn(6, wrote);
    frame_a = pack();
    d = 8'($urandom);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.data = 8'd2; bus.data_valid = 1'b1; tick();
    bus.data = d; bus.stop = 1'b1; busy = 1'b0; tick();
    bus.data_valid = 1'b0; bus.stop = 1'b0;
    mdl[2] = d;
    check("reset_upd1", {71'd0, upd}, 72'd1);
    check("reset_led1", led, frame_a);
    tick();
    check("holdoff_a", {71'd0, upd}, 72'd0);
    tick();
    check("holdoff_b", {71'd0, upd}, 72'd0);
    tick();
    check("reset_upd2", {71'd0, upd}, 72'd1);
    check("reset_led2", led, pack());
    last_led = pack();
    tick(); tick();
    check("reset_two_upd", 72'(upd_cnt - base), 72'd2);

    // start + data_valid together: the byte is dropped
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.data = 8'd0; bus.data_valid = 1'b1; tick();
    bus.start = 1'b1; bus.data = 8'hEE; tick(); bus.start = 1'b0;
    bus.data = 8'd1; tick();
    d = 8'($urandom);
    bus.data = d; tick();
    bus.data_valid = 1'b0; bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    mdl[1] = d;
    expect_refresh("start_dv");

    // data_valid + stop together with the driver idle
    d = 8'($urandom);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.data = 8'd5; bus.data_valid = 1'b1; tick();
    bus.data = d; bus.stop = 1'b1; tick();
    bus.data_valid = 1'b0; bus.stop = 1'b0;
    mdl[5] = d;
    expect_refresh("dv_stop");

    // Reset mid-transaction
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.data = 8'd0; bus.data_valid = 1'b1; tick();
    bus.data = 8'h12; tick();
    bus.data_valid = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1;
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    for (int i = 0; i < NB; i++) mdl[i] = 8'd0;
    last_led = '0;
    expect_none("midrst");
    pay = {8'($urandom), 8'($urandom), 8'($urandom)};
    send_txn(3, wrote);
    expect_refresh("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_led_ctrl.md
# i2c_led_ctrl

Frame controller between the I2C slave byte stream and the WS2812 LED driver. It parses each I2C write transaction as a start byte index followed by colour bytes, stores those bytes in a working frame buffer, and schedules a tear-free refresh of the LED driver after each completed transaction. The I2C slave and LED driver instantiate it between them in `i2c_led`, in place of the unused `leddata` register.

## Interface
- `LED_CNT`, 3: number of LEDs in the chain
- `NBYTES`, derived as `LED_CNT*3`: frame length in bytes (not overridable)
- `DATAWIDTH`, derived as `NBYTES*8`: frame width in bits
- `clk` input 1: system clock
- `reset` input 1: asynchronous, active-low reset
- `data` input 8: received I2C byte, qualified by `data_valid`
- `data_valid` input 1: one-cycle strobe per received byte addressed to this slave
- `start` input 1: one-cycle strobe on an I2C (repeated) start
- `stop` input 1: one-cycle strobe on an I2C stop
- `busy_i` input 1: LED driver is shifting out a frame
- `led_data_o` output DATAWIDTH: shadow frame presented to the LED driver
- `upd_o` output 1: one-cycle strobe that tells the driver to latch `led_data_o` and transmit
- `pending_o` output 1: a refresh is owed but not yet issued

## Operation
- Working buffer `wbuf`: NBYTES bytes. Byte i occupies bits `[DATAWIDTH-1-8*i -: 8]`, so byte 0 is shifted out first (LED0 G, R, B order).
- Pointer `ptr`: width `$clog2(NBYTES)`.
- Flag `dirty`: set when at least one byte has been written in the current transaction.
- FSM states: IDLE, ADDR, DATA, DROP.
  - Any state, `start` → ADDR. Clears `dirty`. `start` has priority, so a `data_valid` in the same cycle is dropped.
  - IDLE: `data_valid` is ignored.
  - ADDR, on `data_valid`: if `data` < NBYTES, set `ptr`=`data` and go to DATA. Otherwise go to DROP.
  - DATA, on `data_valid`: write `wbuf[ptr]`=`data` and set `dirty`. `ptr` advances, wrapping NBYTES-1 → 0.
  - DROP: all bytes are ignored until the next `start` or `stop`.
  - Any state, `stop` → IDLE. If `dirty` is set, set `pending` and clear `dirty`.
  - `data_valid` and `stop` in the same cycle: the byte is processed first, then the stop.
- Refresh scheduler:
  - When `pending` is set, `busy_i` is low and no holdoff is active, assert `upd_o` for one cycle.
  - On that same edge, copy `wbuf` into `led_data_o` and clear `pending`.
  - Holdoff: the cycle after `upd_o`, `busy_i` is treated as high. This covers the driver's one-cycle busy rise.
  - A stop arriving while the driver is busy only sets `pending`. Multiple stops during one transmission coalesce into a single `upd_o`.
  - `pending` set on the same edge that `upd_o` fires: `pending` is re-set, not lost.
- `wbuf` may change during a transmission. `led_data_o` changes only on `upd_o`.
- Reset (`reset`=0, asynchronous):
  - Registers: FSM=IDLE, `ptr`=0, `dirty`=0, `pending`=0, `wbuf`=0.
  - Outputs: `led_data_o`=0, `upd_o`=0, `pending_o`=0.
  - Reset mid-transaction abandons the transaction. No refresh is issued.
- `pending_o` is the registered `pending` flag.

## Timing
- Byte write: `data_valid` in cycle n → `wbuf` updated at edge n+1.
- `stop` in cycle n with the driver idle → `pending_o` high in n+1 → `upd_o` high in n+2, with `led_data_o` valid from n+2. This includes any byte that arrived in cycle n.
- Driver busy: `upd_o` fires in the first cycle in which `busy_i` is sampled low, `pending` is set and holdoff is inactive.
- `upd_o` is never high in two consecutive cycles.
- No combinational path from inputs to outputs.

## Test plan
- Full frame, LED_CNT=3: start, bytes 0x00, 0x11, 0x22, … 0x99 (9 bytes), stop → one `upd_o` 2 cycles after stop, `led_data_o`=0x112233445566778899.
- Partial write with wrap: frame preloaded, then start, 0x08, 0xAA, 0xBB, stop → byte 8=0xAA, byte 0=0xBB, all other bytes unchanged.
- Out-of-range pointer and empty transaction:
  - start, 0x09, 0x55, stop → no write, no `upd_o`.
  - start, stop → no `upd_o`.
- Busy coalescing: `busy_i`=1, then two complete transactions → `pending_o`=1, no `upd_o`. `busy_i` falls → exactly one `upd_o`, `led_data_o` = latest `wbuf`.
- Simultaneous events:
  - `start`+`data_valid` in the same cycle → byte dropped.
  - `data_valid`+`stop` in the same cycle → byte written, `upd_o` follows.
- Reset mid-transaction: start, 0x00, 0x12, then `reset` low for 1 cycle, then stop → all outputs 0, no `upd_o`. Next clean transaction behaves normally.
